// File: rtl/bdm_pkg.sv
// bdm_pkg: definitions shared by the BDM host-side serial blocks.
//   tx_state_t          - encoding of the serial transmitter FSM
//                         (TX_IDLE / TX_START / TX_DATA / TX_PARITY / TX_STOP).
//   CLK_PER_BIT_DEFAULT - default number of clock cycles per serial bit.
package bdm_pkg;

  localparam int CLK_PER_BIT_DEFAULT = 100;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/bdm_sync2.sv
// bdm_sync2: two-flop synchroniser for a single asynchronous level input.
// It is used for host_block here and is meant to be reused on the BKGD input.
// Ports:
//   clk - system clock
//   rst - synchronous, active-high reset (both flops clear to 0)
//   d   - asynchronous input level
//   q   - synchronised level, two clock edges behind d
module bdm_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bdm_serial_tx.sv
// bdm_serial_tx: UART transmitter that sits directly behind the BDM host
// interface. It sends 8N1 frames, or 8E1 frames when the
// BDM_SERIAL_TX_PARITY_EN macro is defined. A one-byte holding register lets
// the next byte be accepted while the current frame is still shifting out.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous, active-high reset
//   new_data   - single-cycle strobe, data is valid this cycle
//   data       - byte to transmit
//   host_block - asynchronous host flow control (host not ready)
//   tx_block   - busy indication back to the host interface
//   tx         - serial line, idle high, registered
//
// Handshake: a byte is taken on any rising edge where new_data = 1 and the
// hold register is empty. tx_block = hold_full | blk_s, and upstream must not
// strobe while it is high. A strobe that arrives while hold_full = 1 is
// dropped and the held byte is kept. A strobe that arrives while only the
// host is blocked (blk_s = 1) is still accepted. host_block never stops a
// frame that has already started. It only keeps a new frame from starting.
//
// The FSM state is kept in the internal signal `state`, so checkers can bind
// to it.
module bdm_serial_tx
  import bdm_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_data,
  input  logic [7:0] data,
  input  logic       host_block,
  output logic       tx_block,
  output logic       tx
);

  localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  tx_state_t           state;
  logic [CTR_SIZE-1:0] ctr;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic [7:0]          hold;
  logic                hold_full;
  logic                blk_s;
`ifdef BDM_SERIAL_TX_PARITY_EN
  logic                parity;
`endif

  logic bit_end;
  logic load_ok;

  bdm_sync2 u_host_block_sync (
    .clk (clk),
    .rst (rst),
    .d   (host_block),
    .q   (blk_s)
  );

  assign tx_block = hold_full | blk_s;
  assign bit_end  = (ctr == CTR_LAST);
  assign load_ok  = hold_full & ~blk_s;

  // The hold register and the FSM share one block. Accept needs an empty hold
  // register and a transfer needs a full one, so the two hold_full updates
  // below never happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      ctr       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      tx        <= 1'b1;
`ifdef BDM_SERIAL_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      if (new_data && !hold_full) begin
        hold      <= data;
        hold_full <= 1'b1;
      end

      // The bit-time counter is free running inside a frame and wraps on
      // every bit boundary.
      ctr <= bit_end ? '0 : ctr + CTR_SIZE'(1);

      case (state)
        TX_IDLE: begin
          ctr <= '0;
          tx  <= 1'b1;
          if (load_ok) begin
            shift     <= hold;
`ifdef BDM_SERIAL_TX_PARITY_EN
            parity    <= ^hold;
`endif
            hold_full <= 1'b0;
            state     <= TX_START;
            tx        <= 1'b0;
          end
        end

        TX_START: begin
          if (bit_end) begin
            state   <= TX_DATA;
            bit_idx <= 3'd0;
            tx      <= shift[0];
          end
        end

        TX_DATA: begin
          if (bit_end) begin
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef BDM_SERIAL_TX_PARITY_EN
              state <= TX_PARITY;
              tx    <= parity;
`else
              state <= TX_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end

        TX_PARITY: begin
          if (bit_end) begin
            state <= TX_STOP;
            tx    <= 1'b1;
          end
        end

        TX_STOP: begin
          if (bit_end) begin
            if (load_ok) begin
              // Go straight into the next start bit so that back-to-back
              // frames have no idle gap between them.
              shift     <= hold;
`ifdef BDM_SERIAL_TX_PARITY_EN
              parity    <= ^hold;
`endif
              hold_full <= 1'b0;
              state     <= TX_START;
              tx        <= 1'b0;
            end else begin
              state <= TX_IDLE;
              tx    <= 1'b1;
            end
          end
        end

        default: begin
          state <= TX_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
